// File: rtl/sprite_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_fetch_ctrl                                                          |
// | Per-pixel dog/duck sprite RAM address generation, hit pipelining,          |
// | priority/transparency resolve and duck flap animation sequencing.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sprite_fetch_ctrl #(
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 20,
    parameter int DUCK_FRAMES = 3,
    parameter int ANIM_DIV    = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic [9:0]  dog_x,
    input  logic [9:0]  dog_y,
    input  logic        dog_en,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic        duck_en,
    input  logic        anim_en,
    output logic [18:0] dog_rd_addr,
    output logic [18:0] duck_rd_addr,
    input  logic [2:0]  dog_data,
    input  logic [2:0]  duck_data,
    output logic        out_valid,
    output logic [2:0]  out_color,
    output logic [1:0]  out_sel,
    output logic [1:0]  anim_frame
);

    localparam int c_CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int c_FRAME_SZ = SPR_W * SPR_H;

    logic [10:0] w_x, w_y;
    logic [10:0] w_dog_x, w_dog_y, w_duck_x, w_duck_y;
    logic [10:0] w_dog_dx, w_dog_dy, w_duck_dx, w_duck_dy;
    logic        w_dog_hit, w_duck_hit;
    logic [18:0] w_dog_addr, w_duck_addr;
    logic [1:0]  w_sel;
    logic [2:0]  w_color;

    logic [18:0]        r_dog_addr, r_duck_addr;
    logic               r_pv_d1, r_dog_hit_d1, r_duck_hit_d1;
    logic               r_pv_d2, r_dog_hit_d2, r_duck_hit_d2;
    logic               r_out_valid;
    logic [1:0]         r_out_sel;
    logic [2:0]         r_out_color;
    logic [c_CNT_W-1:0] r_anim_cnt;
    logic [1:0]         r_anim_frame;

    // Widen to 11 bits so position+size near the right/bottom edge cannot wrap.
    assign w_x      = {1'b0, DrawX};
    assign w_y      = {1'b0, DrawY};
    assign w_dog_x  = {1'b0, dog_x};
    assign w_dog_y  = {1'b0, dog_y};
    assign w_duck_x = {1'b0, duck_x};
    assign w_duck_y = {1'b0, duck_y};

    assign w_dog_dx  = w_x - w_dog_x;
    assign w_dog_dy  = w_y - w_dog_y;
    assign w_duck_dx = w_x - w_duck_x;
    assign w_duck_dy = w_y - w_duck_y;

    assign w_dog_hit  = pix_valid && dog_en
                     && (w_x >= w_dog_x) && (w_x < w_dog_x + 11'(SPR_W))
                     && (w_y >= w_dog_y) && (w_y < w_dog_y + 11'(SPR_H));
    assign w_duck_hit = pix_valid && duck_en
                     && (w_x >= w_duck_x) && (w_x < w_duck_x + 11'(SPR_W))
                     && (w_y >= w_duck_y) && (w_y < w_duck_y + 11'(SPR_H));

    assign w_dog_addr  = 19'(w_dog_dy) * 19'(SPR_W) + 19'(w_dog_dx);
    assign w_duck_addr = 19'(r_anim_frame) * 19'(c_FRAME_SZ)
                       + 19'(w_duck_dy) * 19'(SPR_W) + 19'(w_duck_dx);

    // Duck is drawn in front of the dog; data value 0 is transparent.
    always_comb begin
        w_sel   = 2'd0;
        w_color = 3'd0;
        if (r_duck_hit_d2 && (duck_data != 3'd0)) begin
            w_sel   = 2'd2;
            w_color = duck_data;
        end else if (r_dog_hit_d2 && (dog_data != 3'd0)) begin
            w_sel   = 2'd1;
            w_color = dog_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dog_addr    <= '0;
            r_duck_addr   <= '0;
            r_pv_d1       <= 1'b0;
            r_dog_hit_d1  <= 1'b0;
            r_duck_hit_d1 <= 1'b0;
            r_pv_d2       <= 1'b0;
            r_dog_hit_d2  <= 1'b0;
            r_duck_hit_d2 <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sel     <= 2'd0;
            r_out_color   <= 3'd0;
        end else begin
            r_dog_addr    <= w_dog_hit  ? w_dog_addr  : '0;
            r_duck_addr   <= w_duck_hit ? w_duck_addr : '0;
            r_pv_d1       <= pix_valid;
            r_dog_hit_d1  <= w_dog_hit;
            r_duck_hit_d1 <= w_duck_hit;
            r_pv_d2       <= r_pv_d1;
            r_dog_hit_d2  <= r_dog_hit_d1;
            r_duck_hit_d2 <= r_duck_hit_d1;
            r_out_valid   <= r_pv_d2;
            r_out_sel     <= w_sel;
            r_out_color   <= w_color;
        end
    end

    // Frame only advances on a frame_start edge, so a frame is never torn.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_anim_cnt   <= '0;
            r_anim_frame <= 2'd0;
        end else if (frame_start && anim_en) begin
            if (r_anim_cnt == c_CNT_W'(ANIM_DIV - 1)) begin
                r_anim_cnt   <= '0;
                r_anim_frame <= (r_anim_frame == 2'(DUCK_FRAMES - 1)) ? 2'd0
                                                                      : r_anim_frame + 2'd1;
            end else begin
                r_anim_cnt <= r_anim_cnt + 1'b1;
            end
        end
    end

    assign dog_rd_addr  = r_dog_addr;
    assign duck_rd_addr = r_duck_addr;
    assign out_valid    = r_out_valid;
    assign out_sel      = r_out_sel;
    assign out_color    = r_out_color;
    assign anim_frame   = r_anim_frame;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprite_fetch_ctrl                                                       |
// | Directed vector table plus multi-cycle sequences for sprite_fetch_ctrl.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sprite_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, dog_x, dog_y, duck_x, duck_y;
    logic        pix_valid, frame_start, dog_en, duck_en, anim_en;
    logic [18:0] dog_rd_addr, duck_rd_addr;
    logic [2:0]  dog_data, duck_data;
    logic        out_valid;
    logic [2:0]  out_color;
    logic [1:0]  out_sel, anim_frame;

    int checks   = 0;
    int failures = 0;

    logic       ram_fixed;
    logic [2:0] fix_dog, fix_duck;

    sprite_fetch_ctrl #(
        .SPR_W(20), .SPR_H(20), .DUCK_FRAMES(3), .ANIM_DIV(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .dog_x(dog_x), .dog_y(dog_y), .dog_en(dog_en),
        .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en),
        .anim_en(anim_en), .dog_rd_addr(dog_rd_addr), .duck_rd_addr(duck_rd_addr),
        .dog_data(dog_data), .duck_data(duck_data), .out_valid(out_valid),
        .out_color(out_color), .out_sel(out_sel), .anim_frame(anim_frame)
    );

    always #5 Clk = ~Clk;

    // Single-cycle-latency sprite RAM models.
    always @(posedge Clk) begin
        dog_data  <= ram_fixed ? fix_dog  : 3'(dog_rd_addr % 7);
        duck_data <= ram_fixed ? fix_duck : 3'(duck_rd_addr % 6);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  x, y;
        logic        pv;
        logic [9:0]  dgx, dgy;
        logic        dge;
        logic [9:0]  dkx, dky;
        logic        dke;
        logic [2:0]  dd, kd;
        logic [18:0] e_da, e_ka;
        logic        e_v;
        logic [1:0]  e_sel;
        logic [2:0]  e_col;
    } vec_t;

    vec_t vecs[10];

    int exp_sel[640];
    int exp_col[640];

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0; frame_start = 1'b0;
        dog_x = 10'd100; dog_y = 10'd50; dog_en = 1'b1;
        duck_x = '0; duck_y = '0; duck_en = 1'b0; anim_en = 1'b0;
        ram_fixed = 1'b1; fix_dog = 3'd4; fix_duck = 3'd0;

        //            x     y   pv  dgx  dgy dge  dkx   dky dke dd kd  e_da e_ka v sel col
        vecs[0] = '{10'd105, 10'd53, 1, 10'd100, 10'd50, 1, 10'd0, 10'd0, 0, 3'd4, 3'd0, 19'd65, 19'd0, 1, 2'd1, 3'd4};
        vecs[1] = '{10'd99, 10'd53, 1, 10'd100, 10'd50, 1, 10'd0, 10'd0, 0, 3'd4, 3'd0, 19'd0, 19'd0, 1, 2'd0, 3'd0};
        vecs[2] = '{10'd120, 10'd53, 1, 10'd100, 10'd50, 1, 10'd0, 10'd0, 0, 3'd4, 3'd0, 19'd0, 19'd0, 1, 2'd0, 3'd0};
        vecs[3] = '{10'd119, 10'd69, 1, 10'd100, 10'd50, 1, 10'd0, 10'd0, 0, 3'd1, 3'd0, 19'd399, 19'd0, 1, 2'd1, 3'd1};
        vecs[4] = '{10'd210, 10'd210, 1, 10'd200, 10'd200, 1, 10'd200, 10'd200, 1, 3'd3, 3'd5, 19'd210, 19'd210, 1, 2'd2, 3'd5};
        vecs[5] = '{10'd210, 10'd210, 1, 10'd200, 10'd200, 1, 10'd200, 10'd200, 1, 3'd3, 3'd0, 19'd210, 19'd210, 1, 2'd1, 3'd3};
        vecs[6] = '{10'd3, 10'd0, 1, 10'd0, 10'd0, 0, 10'd1015, 10'd0, 1, 3'd2, 3'd6, 19'd0, 19'd0, 1, 2'd0, 3'd0};
        vecs[7] = '{10'd1020, 10'd0, 1, 10'd0, 10'd0, 0, 10'd1015, 10'd0, 1, 3'd2, 3'd6, 19'd0, 19'd5, 1, 2'd2, 3'd6};
        vecs[8] = '{10'd105, 10'd53, 0, 10'd100, 10'd50, 1, 10'd0, 10'd0, 0, 3'd4, 3'd0, 19'd0, 19'd0, 0, 2'd0, 3'd0};
        vecs[9] = '{10'd209, 10'd200, 1, 10'd200, 10'd200, 1, 10'd210, 10'd200, 1, 3'd2, 3'd7, 19'd9, 19'd0, 1, 2'd1, 3'd2};

        // Reset held 3 cycles with a hitting pixel present.
        DrawX = 10'd105; DrawY = 10'd53; pix_valid = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_dog_addr", int'(dog_rd_addr), 0);
        chk("rst_duck_addr", int'(duck_rd_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_out_color", int'(out_color), 0);
        chk("rst_anim_frame", int'(anim_frame), 0);
        Reset = 1'b0; pix_valid = 1'b0;
        @(negedge Clk); chk("post_rst_v1", int'(out_valid), 0);
        @(negedge Clk); chk("post_rst_v2", int'(out_valid), 0);
        @(negedge Clk); chk("post_rst_v3", int'(out_valid), 0);
        pix_valid = 1'b1;
        @(negedge Clk); pix_valid = 1'b0; chk("first_lat_k", int'(out_valid), 0);
        @(negedge Clk); chk("first_lat_k1", int'(out_valid), 0);
        @(negedge Clk); chk("first_lat_k2", int'(out_valid), 1);
        @(negedge Clk); chk("first_lat_k3", int'(out_valid), 0);

        for (int i = 0; i < 10; i++) begin
            DrawX = vecs[i].x; DrawY = vecs[i].y; pix_valid = vecs[i].pv;
            dog_x = vecs[i].dgx; dog_y = vecs[i].dgy; dog_en = vecs[i].dge;
            duck_x = vecs[i].dkx; duck_y = vecs[i].dky; duck_en = vecs[i].dke;
            fix_dog = vecs[i].dd; fix_duck = vecs[i].kd;
            @(negedge Clk);
            chk($sformatf("v%0d_dog_addr", i), int'(dog_rd_addr), int'(vecs[i].e_da));
            chk($sformatf("v%0d_duck_addr", i), int'(duck_rd_addr), int'(vecs[i].e_ka));
            pix_valid = 1'b0;
            @(negedge Clk);
            @(negedge Clk);
            chk($sformatf("v%0d_valid", i), int'(out_valid), int'(vecs[i].e_v));
            chk($sformatf("v%0d_sel", i), int'(out_sel), int'(vecs[i].e_sel));
            chk($sformatf("v%0d_color", i), int'(out_color), int'(vecs[i].e_col));
        end

        // Animation: frame steps every 8 enabled frame_start pulses.
        dog_en = 1'b0; duck_en = 1'b1; duck_x = 10'd50; duck_y = 10'd60;
        anim_en = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            frame_start = 1'b1;
            @(negedge Clk);
            frame_start = 1'b0;
            chk($sformatf("anim_p%0d", n), int'(anim_frame), (n / 8) % 3);
            if (n == 16) begin
                DrawX = 10'd50; DrawY = 10'd60; pix_valid = 1'b1;
                @(negedge Clk);
                pix_valid = 1'b0;
                chk("anim_f2_addr", int'(duck_rd_addr), 800);
            end
        end
        // 24th pulse coincides with a pixel: address must use the pre-edge frame.
        DrawX = 10'd51; DrawY = 10'd60; pix_valid = 1'b1; frame_start = 1'b1;
        @(negedge Clk);
        pix_valid = 1'b0; frame_start = 1'b0;
        chk("anim_simul_addr", int'(duck_rd_addr), 801);
        chk("anim_p24", int'(anim_frame), 0);

        anim_en = 1'b0;
        repeat (8) begin
            frame_start = 1'b1; @(negedge Clk);
            frame_start = 1'b0; @(negedge Clk);
        end
        chk("anim_disabled", int'(anim_frame), 0);
        anim_en = 1'b1;
        frame_start = 1'b1; @(negedge Clk); frame_start = 1'b0;
        chk("anim_cnt_held", int'(anim_frame), 0);
        @(negedge Clk); @(negedge Clk);

        // Streaming a full row through both sprites.
        Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
        dog_x = 10'd300; dog_y = 10'd100; dog_en = 1'b1;
        duck_x = 10'd310; duck_y = 10'd105; duck_en = 1'b1;
        ram_fixed = 1'b0;
        for (int x = 0; x < 640; x++) begin
            bit dh, kh;
            int da, ka, dd, kd;
            dh = (x >= 300) && (x < 320);
            kh = (x >= 310) && (x < 330);
            da = dh ? (110 - 100) * 20 + (x - 300) : 0;
            ka = kh ? (110 - 105) * 20 + (x - 310) : 0;
            dd = da % 7;
            kd = ka % 6;
            if (kh && kd != 0) begin
                exp_sel[x] = 2; exp_col[x] = kd;
            end else if (dh && dd != 0) begin
                exp_sel[x] = 1; exp_col[x] = dd;
            end else begin
                exp_sel[x] = 0; exp_col[x] = 0;
            end
        end
        DrawY = 10'd110;
        for (int i = 0; i < 644; i++) begin
            if (i >= 3 && i < 643) begin
                chk($sformatf("s%0d_valid", i - 3), int'(out_valid), 1);
                chk($sformatf("s%0d_sel", i - 3), int'(out_sel), exp_sel[i - 3]);
                chk($sformatf("s%0d_color", i - 3), int'(out_color), exp_col[i - 3]);
            end
            if (i == 643) chk("stream_end_valid", int'(out_valid), 0);
            if (i < 640) begin
                DrawX = 10'(i); pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_fetch_ctrl.md
# sprite_fetch_ctrl

Per-pixel sprite fetch controller for the dog and duck sprite frame RAMs. It takes the VGA scan position and the sprite positions, and generates the read addresses for both single-cycle-latency sprite RAMs. It pipelines hit flags across the RAM read latency and resolves priority and transparency into one palette index per pixel. It also sequences the duck's flap animation, advancing the frame only at frame boundaries so there is no mid-frame tearing.

## Interface
Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- DUCK_FRAMES, 3, animation frames stored back-to-back in duck RAM (frame f at base f*SPR_W*SPR_H)
- ANIM_DIV, 8, frame_start pulses per animation step

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- DrawX, DrawY  in  10 each  current scan pixel
- pix_valid  in  1  DrawX/DrawY is a visible pixel this cycle
- frame_start  in  1  one-cycle pulse per video frame (vsync)
- dog_x, dog_y  in  10 each  dog top-left
- dog_en  in  1  dog visible
- duck_x, duck_y  in  10 each  duck top-left
- duck_en  in  1  duck visible
- anim_en  in  1  allow animation stepping
- dog_rd_addr  out  19  to dog RAM read_address
- duck_rd_addr  out  19  to duck RAM read_address
- dog_data, duck_data  in  3 each  RAM data_Out, valid one cycle after the address is registered
- out_valid  out  1  out_color/out_sel valid
- out_color  out  3  resolved palette index; 0 = background
- out_sel  out  2  0 background, 1 dog, 2 duck
- anim_frame  out  2  current duck frame, 0..DUCK_FRAMES-1

## Operation
- Stage 0 (input edge k): hit tests use 11-bit unsigned arithmetic, so x+SPR_W near 1023 does not wrap.
  - dog_hit = pix_valid & dog_en & DrawX>=dog_x & DrawX<dog_x+SPR_W & DrawY>=dog_y & DrawY<dog_y+SPR_H.
  - duck_hit is the same test against duck_x/duck_y/duck_en.
- Addresses are registered at edge k:
  - dog_rd_addr = (DrawY-dog_y)*SPR_W + (DrawX-dog_x) when dog_hit, else 0.
  - duck_rd_addr = anim_frame*SPR_W*SPR_H + (DrawY-duck_y)*SPR_W + (DrawX-duck_x) when duck_hit, else 0.
- Stage 1 (edge k+1): the RAMs register their data; the controller delays pix_valid, dog_hit and duck_hit by one more stage.
- Stage 2 (edge k+2): priority and transparency are resolved; index 0 in sprite data means transparent.
  - duck_hit_d2 & duck_data!=0 → out_sel=2, out_color=duck_data.
  - else dog_hit_d2 & dog_data!=0 → out_sel=1, out_color=dog_data.
  - else out_sel=0, out_color=0.
  - out_valid = pix_valid delayed two cycles.
- Animation counter:
  - On frame_start with anim_en=1, anim_cnt increments.
  - When anim_cnt==ANIM_DIV-1, anim_cnt→0 and anim_frame→(anim_frame+1) mod DUCK_FRAMES.
  - frame_start with anim_en=0 leaves both unchanged.
  - anim_frame changes only on a frame_start edge.
- Simultaneous frame_start and pix_valid: stage 0 uses the pre-edge anim_frame.

## Timing
- Latency: pixel in at edge k → out at edge k+2. Fully pipelined, one pixel per cycle, no stalls, no backpressure.
- Reset (synchronous, edge with Reset=1) clears:
  - all outputs to 0 (dog_rd_addr, duck_rd_addr, out_valid, out_color, out_sel, anim_frame);
  - anim_cnt and every pipeline valid/hit flag.
- Pixels in flight when Reset asserts are discarded; out_valid=0 for the two cycles after Reset deasserts unless pix_valid was asserted.
- Position inputs are sampled at stage 0 only; changing them mid-frame affects subsequent pixels only.
- Sprite RAM writes are outside this block; the controller never drives `we`.

## Test plan
- Reset: hold Reset 3 cycles with pix_valid=1 → all outputs 0; first out_valid exactly 2 cycles after the first post-reset pix_valid.
- Dog only: dog_x=100, dog_y=50, dog_en=1; pixel (105,53) → dog_rd_addr=65 at edge k; with RAM model returning 4, out_sel=1 and out_color=4 at k+2. Pixels (99,53) and (120,53) → out_sel=0.
- Overlap and transparency: dog and duck both at (200,200).
  - Pixel (210,210) with duck_data=5 → out_sel=2, out_color=5.
  - Same pixel with duck_data=0, dog_data=3 → out_sel=1, out_color=3.
- Animation: ANIM_DIV=8, anim_en=1, 24 frame_start pulses → anim_frame sequence 0→1→2→0, stepping at the 8th, 16th and 24th pulses. With anim_frame=2, duck pixel (x+0,y+0) → duck_rd_addr=800. Pulses with anim_en=0 → no change.
- Edge wrap: duck_x=1015, pixel DrawX=3 → no hit (no 10-bit wrap); DrawX=1020 → hit, column offset 5.
- Streaming: 640 consecutive pix_valid pixels across a sprite row → 640 consecutive out_valid cycles, each output matching the golden model delayed 2 cycles.
